// File: rtl/eae_sequencer_if.sv
// eae_sequencer_if: CPU request/response and EAE handshake signals shared
// between the sequencer (slave view) and the CPU/EAE side (master view).
interface eae_sequencer_if;
  // CPU request side
  logic        req_valid;
  logic [1:0]  req_op;
  logic [11:0] ac_in;
  logic [11:0] mq_in;
  logic [11:0] mb_in;
  logic        req_ready;

  // EAE start and latched operands
  logic        eae_start;
  logic [11:0] eae_ac;
  logic [11:0] eae_mq;
  logic [11:0] eae_mb;

  // EAE completion strobes and result registers
  logic        eae_fin_mul;
  logic        eae_fin_dvi;
  logic [11:0] ac_mul;
  logic [11:0] mq_mul;
  logic [11:0] ac_dvi;
  logic [11:0] mq_dvi;
  logic        link_dvi;

  // CPU completion side
  logic        done;
  logic [11:0] ac_out;
  logic [11:0] mq_out;
  logic        link_out;
  logic        link_we;
  logic        error;

  modport slave (
    input  req_valid, req_op, ac_in, mq_in, mb_in,
    input  eae_fin_mul, eae_fin_dvi, ac_mul, mq_mul, ac_dvi, mq_dvi, link_dvi,
    output req_ready, eae_start, eae_ac, eae_mq, eae_mb,
    output done, ac_out, mq_out, link_out, link_we, error
  );

  modport master (
    output req_valid, req_op, ac_in, mq_in, mb_in,
    output eae_fin_mul, eae_fin_dvi, ac_mul, mq_mul, ac_dvi, mq_dvi, link_dvi,
    input  req_ready, eae_start, eae_ac, eae_mq, eae_mb,
    input  done, ac_out, mq_out, link_out, link_we, error
  );
endinterface

// File: rtl/eae_sequencer.sv
// eae_sequencer: accepts a MUY/DVI request from the CPU, screens illegal ops
// and divide overflow, starts the EAE, waits (bounded) for the matching
// completion strobe and returns a one-cycle done with results and link.
module eae_sequencer #(
  parameter int TIMEOUT = 31
) (
  input logic           clock,
  input logic           reset,
  eae_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    START,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [1:0] OP_MUY = 2'b01;
  localparam logic [1:0] OP_DVI = 2'b10;

  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int CNT_W1 = CNT_W + 1;
  localparam logic [CNT_W:0] CNT_LAST = CNT_W1'(TIMEOUT);
  localparam logic [CNT_W:0] CNT_ONE  = CNT_W1'(1);

  state_t            state_q;
  logic [CNT_W-1:0]  waitCnt_q;
  logic [1:0]        op_q;
  logic [11:0]       ac_q;
  logic [11:0]       mq_q;
  logic [11:0]       mb_q;

  logic              reqReady_q;
  logic              eaeStart_q;
  logic              done_q;
  logic              error_q;
  logic              linkOut_q;
  logic              linkWe_q;
  logic [11:0]       acOut_q;
  logic [11:0]       mqOut_q;

  logic              opIsMuy;
  logic              opIsDvi;
  logic              dviOverflow;
  logic              finSeen;
  logic [CNT_W:0]    cntNext;

  // Decode the latched op, divide overflow, the relevant strobe and the next wait count.
  always_comb begin
    opIsMuy     = (op_q == OP_MUY);
    opIsDvi     = (op_q == OP_DVI);
    dviOverflow = (mb_q == 12'd0) || (ac_q >= mb_q);
    finSeen     = opIsMuy ? bus.eae_fin_mul : bus.eae_fin_dvi;
    cntNext     = {1'b0, waitCnt_q} + CNT_ONE;
  end

  // Sequencer FSM: state, operand latches, wait counter and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      waitCnt_q  <= '0;
      op_q       <= '0;
      ac_q       <= '0;
      mq_q       <= '0;
      mb_q       <= '0;
      reqReady_q <= 1'b1;
      eaeStart_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      linkOut_q  <= 1'b0;
      linkWe_q   <= 1'b0;
      acOut_q    <= '0;
      mqOut_q    <= '0;
    end else begin
      eaeStart_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      linkOut_q  <= 1'b0;
      linkWe_q   <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            op_q       <= bus.req_op;
            ac_q       <= bus.ac_in;
            mq_q       <= bus.mq_in;
            mb_q       <= bus.mb_in;
            reqReady_q <= 1'b0;
            state_q    <= CHECK;
          end
        end

        CHECK: begin
          if (!opIsMuy && !opIsDvi) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            error_q <= 1'b1;
            acOut_q <= ac_q;
            mqOut_q <= mq_q;
          end else if (opIsDvi && dviOverflow) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            linkOut_q <= 1'b1;
            linkWe_q  <= 1'b1;
            acOut_q   <= ac_q;
            mqOut_q   <= mq_q;
          end else begin
            state_q    <= START;
            eaeStart_q <= 1'b1;
          end
        end

        START: begin
          waitCnt_q <= '0;
          state_q   <= WAIT;
        end

        WAIT: begin
          if (finSeen) begin
            state_q <= CAPTURE;
          end else if (cntNext == CNT_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            error_q <= 1'b1;
            acOut_q <= ac_q;
            mqOut_q <= mq_q;
          end else begin
            waitCnt_q <= cntNext[CNT_W-1:0];
          end
        end

        CAPTURE: begin
          state_q  <= DONE;
          done_q   <= 1'b1;
          linkWe_q <= 1'b1;
          if (opIsDvi) begin
            acOut_q   <= bus.ac_dvi;
            mqOut_q   <= bus.mq_dvi;
            linkOut_q <= bus.link_dvi;
          end else begin
            acOut_q   <= bus.ac_mul;
            mqOut_q   <= bus.mq_mul;
            linkOut_q <= 1'b0;
          end
        end

        DONE: begin
          state_q    <= IDLE;
          reqReady_q <= 1'b1;
        end

        default: begin
          state_q    <= IDLE;
          reqReady_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = reqReady_q;
  assign bus.eae_start = eaeStart_q;
  assign bus.eae_ac    = ac_q;
  assign bus.eae_mq    = mq_q;
  assign bus.eae_mb    = mb_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.link_out  = linkOut_q;
  assign bus.link_we   = linkWe_q;
  assign bus.ac_out    = acOut_q;
  assign bus.mq_out    = mqOut_q;

endmodule

// File: tb/tb_eae_sequencer.sv
// tb_eae_sequencer: table vectors, hand-written reset/busy sequences and
// randomized transactions checked against a rule-level reference model.
module tb_eae_sequencer;

  localparam int         TIMEOUT = 31;
  localparam logic [1:0] MUY     = 2'b01;
  localparam logic [1:0] DVI     = 2'b10;
  localparam int         NEVER   = 1000;
  localparam int         NVEC    = 13;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [11:0] ac;
    logic [11:0] mq;
    logic [11:0] mb;
    int          finDly;
    int          wrongDly;
    logic [11:0] rAc;
    logic [11:0] rMq;
    logic        rLink;
    logic        expStart;
    int          expLat;
    logic        expErr;
    logic        chkWe;
    logic        expWe;
    logic        chkLink;
    logic        expLink;
    logic        chkData;
    logic [11:0] expAc;
    logic [11:0] expMq;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  vec_t tbl[NVEC];

  eae_sequencer_if bus();

  eae_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Time limit so a stuck run still ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Expected outcome from the sequencing rules alone.
  function automatic vec_t model(input vec_t v);
    vec_t e;
    bit   isDvi;
    bit   legal;
    e       = v;
    isDvi   = (v.op == DVI);
    legal   = (v.op == MUY) || isDvi;
    e.chkWe = 1; e.chkLink = 1; e.chkData = 1; e.expErr = 0;
    if (!legal) begin
      e.expStart = 0; e.expLat = 2; e.expErr = 1;
      e.chkWe = 0; e.chkLink = 0; e.chkData = 0;
      e.expWe = 0; e.expLink = 0; e.expAc = 0; e.expMq = 0;
    end else if (isDvi && (v.mb == 0 || v.ac >= v.mb)) begin
      e.expStart = 0; e.expLat = 2; e.expWe = 1; e.expLink = 1;
      e.expAc = v.ac; e.expMq = v.mq;
    end else if (v.finDly >= 1 && v.finDly <= TIMEOUT) begin
      e.expStart = 1; e.expLat = 2 + v.finDly + 2; e.expWe = 1;
      e.expLink = isDvi ? v.rLink : 1'b0;
      e.expAc = v.rAc; e.expMq = v.rMq;
    end else begin
      e.expStart = 1; e.expLat = 2 + TIMEOUT + 1; e.expErr = 1;
      e.expWe = 0; e.chkLink = 0; e.expLink = 0;
      e.expAc = v.ac; e.expMq = v.mq;
    end
    return e;
  endfunction

  // One full transaction: accept, play the EAE side, observe done, compare.
  task automatic applyStimulus(input vec_t v, input bit holdValid);
    int          startRel, doneRel, starts, dones, guard;
    bit          readyBad, operBad, strayBad;
    logic        readyAfter, gotErr, gotWe, gotLink;
    logic [11:0] gotAc, gotMq;
    startRel = -1; doneRel = -1; starts = 0; dones = 0; guard = 0;
    readyBad = 0; operBad = 0; strayBad = 0;
    readyAfter = 1'b0; gotErr = 1'b0; gotWe = 1'b0; gotLink = 1'b0;
    gotAc = '0; gotMq = '0;

    @(negedge clock);
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    checkOutput({v.name, "_ready"}, 32'(bus.req_ready), 1);

    if (v.op == DVI) begin
      bus.ac_dvi = v.rAc;  bus.mq_dvi = v.rMq;  bus.link_dvi = v.rLink;
      bus.ac_mul = ~v.rAc; bus.mq_mul = ~v.rMq;
    end else begin
      bus.ac_mul = v.rAc;  bus.mq_mul = v.rMq;
      bus.ac_dvi = ~v.rAc; bus.mq_dvi = ~v.rMq; bus.link_dvi = 1'b1;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = v.op;
    bus.ac_in     = v.ac;
    bus.mq_in     = v.mq;
    bus.mb_in     = v.mb;

    for (int rel = 1; rel <= 60; rel++) begin
      @(negedge clock);
      if (rel == 1) begin
        bus.req_valid = holdValid;
        bus.ac_in     = 12'($urandom);
        bus.mq_in     = 12'($urandom);
        bus.mb_in     = 12'($urandom);
      end
      if (doneRel >= 0 && rel == doneRel + 1) readyAfter = bus.req_ready;
      if (bus.eae_start === 1'b1) begin
        starts++;
        if (startRel < 0) startRel = rel;
      end
      if (doneRel < 0 && bus.req_ready !== 1'b0) readyBad = 1;
      if (bus.done === 1'b1) begin
        dones++;
        if (doneRel < 0) begin
          doneRel = rel;
          gotAc = bus.ac_out; gotMq = bus.mq_out;
          gotErr = bus.error; gotWe = bus.link_we; gotLink = bus.link_out;
          bus.req_valid = 1'b0;
        end
      end else if (bus.error !== 1'b0 || bus.link_we !== 1'b0) begin
        strayBad = 1;
      end
      if (startRel >= 0 && doneRel < 0 &&
          (bus.eae_ac !== v.ac || bus.eae_mq !== v.mq || bus.eae_mb !== v.mb))
        operBad = 1;
      bus.eae_fin_mul = 1'b0;
      bus.eae_fin_dvi = 1'b0;
      if (startRel >= 0) begin
        if (rel == startRel + v.finDly) begin
          if (v.op == DVI) bus.eae_fin_dvi = 1'b1;
          else             bus.eae_fin_mul = 1'b1;
        end
        if (v.wrongDly > 0 && rel == startRel + v.wrongDly) begin
          if (v.op == DVI) bus.eae_fin_mul = 1'b1;
          else             bus.eae_fin_dvi = 1'b1;
        end
      end
      if (doneRel >= 0 && rel >= doneRel + 3) break;
    end
    bus.eae_fin_mul = 1'b0;
    bus.eae_fin_dvi = 1'b0;
    bus.req_valid   = 1'b0;

    checkOutput({v.name, "_latency"}, 32'(doneRel), 32'(v.expLat));
    checkOutput({v.name, "_starts"}, 32'(starts), v.expStart ? 1 : 0);
    if (v.expStart) checkOutput({v.name, "_start_cycle"}, 32'(startRel), 2);
    checkOutput({v.name, "_done_count"}, 32'(dones), 1);
    checkOutput({v.name, "_error"}, 32'(gotErr), 32'(v.expErr));
    if (v.chkWe)   checkOutput({v.name, "_link_we"}, 32'(gotWe), 32'(v.expWe));
    if (v.chkLink) checkOutput({v.name, "_link_out"}, 32'(gotLink), 32'(v.expLink));
    if (v.chkData) begin
      checkOutput({v.name, "_ac_out"}, 32'(gotAc), 32'(v.expAc));
      checkOutput({v.name, "_mq_out"}, 32'(gotMq), 32'(v.expMq));
    end
    checkOutput({v.name, "_busy_ready_high"}, 32'(readyBad), 0);
    checkOutput({v.name, "_stray_err_we"}, 32'(strayBad), 0);
    if (v.expStart) checkOutput({v.name, "_operands_unstable"}, 32'(operBad), 0);
    checkOutput({v.name, "_ready_after_done"}, 32'(readyAfter), 1);
  endtask

  initial begin
    vec_t h;
    vec_t r;
    int   dones;
    int   readyDrops;
    int   guard;
    int   sel;

    //          name            op     ac      mq        mb     fin    wrg rAc       rMq      rL  St  Lat Err cWe We cLk Lk cD expAc     expMq
    tbl[0]  = '{"muy_basic",     MUY,  12'o0,  12'o12,   12'o3, 5,     0,  12'o0,    12'o36,  0,  1,  9,  0,  1,  1, 1,  0, 1, 12'o0,    12'o36};
    tbl[1]  = '{"dvi_basic",     DVI,  12'o0,  12'o17,   12'o4, 3,     0,  12'o3,    12'o3,   0,  1,  7,  0,  1,  1, 1,  0, 1, 12'o3,    12'o3};
    tbl[2]  = '{"dvi_ovf",       DVI,  12'o5,  12'o1234, 12'o4, 3,     0,  12'o7,    12'o7,   0,  0,  2,  0,  1,  1, 1,  1, 1, 12'o5,    12'o1234};
    tbl[3]  = '{"dvi_mb0",       DVI,  12'o0,  12'o77,   12'o0, 3,     0,  12'o7,    12'o7,   0,  0,  2,  0,  1,  1, 1,  1, 1, 12'o0,    12'o77};
    tbl[4]  = '{"dvi_equal",     DVI,  12'o3,  12'o11,   12'o3, 3,     0,  12'o1,    12'o1,   0,  0,  2,  0,  1,  1, 1,  1, 1, 12'o3,    12'o11};
    tbl[5]  = '{"muy_timeout",   MUY,  12'o12, 12'o34,   12'o56, NEVER, 0, 12'o1,    12'o1,   0,  1,  34, 1,  1,  0, 0,  0, 1, 12'o12,   12'o34};
    tbl[6]  = '{"muy_tmo_edge",  MUY,  12'o1,  12'o2,    12'o3, 31,    0,  12'o7777, 12'o1,   0,  1,  35, 0,  1,  1, 1,  0, 1, 12'o7777, 12'o1};
    tbl[7]  = '{"dvi_tmo_late",  DVI,  12'o1,  12'o2,    12'o3, 32,    0,  12'o5,    12'o5,   1,  1,  34, 1,  1,  0, 0,  0, 1, 12'o1,    12'o2};
    tbl[8]  = '{"illegal_11",    2'b11, 12'o4, 12'o5,    12'o6, 3,     0,  12'o0,    12'o0,   0,  0,  2,  1,  0,  0, 0,  0, 0, 12'o0,    12'o0};
    tbl[9]  = '{"illegal_00",    2'b00, 12'o4, 12'o5,    12'o6, 3,     0,  12'o0,    12'o0,   0,  0,  2,  1,  0,  0, 0,  0, 0, 12'o0,    12'o0};
    tbl[10] = '{"dvi_link_fast", DVI,  12'o3,  12'o0,    12'o4, 1,     0,  12'o6,    12'o2,   1,  1,  5,  0,  1,  1, 1,  1, 1, 12'o6,    12'o2};
    tbl[11] = '{"muy_wrong_stb", MUY,  12'o7,  12'o7,    12'o7, 6,     2,  12'o61,   12'o1,   0,  1,  10, 0,  1,  1, 1,  0, 1, 12'o61,   12'o1};
    tbl[12] = '{"dvi_wrong_stb", DVI,  12'o1,  12'o5,    12'o7, 4,     1,  12'o2,    12'o3,   0,  1,  8,  0,  1,  1, 1,  0, 1, 12'o2,    12'o3};

    reset           = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_op      = 2'b00;
    bus.ac_in       = '0;
    bus.mq_in       = '0;
    bus.mb_in       = '0;
    bus.eae_fin_mul = 1'b0;
    bus.eae_fin_dvi = 1'b0;
    bus.ac_mul      = '0;
    bus.mq_mul      = '0;
    bus.ac_dvi      = '0;
    bus.mq_dvi      = '0;
    bus.link_dvi    = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    checkOutput("reset_req_ready", 32'(bus.req_ready), 1);
    checkOutput("reset_done", 32'(bus.done), 0);
    checkOutput("reset_eae_start", 32'(bus.eae_start), 0);
    checkOutput("reset_error", 32'(bus.error), 0);
    checkOutput("reset_link_we", 32'(bus.link_we), 0);
    checkOutput("reset_ac_out", 32'(bus.ac_out), 0);

    for (int i = 0; i < NVEC; i++) applyStimulus(tbl[i], 1'b0);

    h = tbl[0]; h.name = "muy_hold_valid";  applyStimulus(h, 1'b1);
    h = tbl[8]; h.name = "ill_hold_valid";  applyStimulus(h, 1'b1);
    h = tbl[2]; h.name = "ovf_hold_valid";  applyStimulus(h, 1'b1);

    // Reset pulsed mid-WAIT, then a late strobe that must not complete anything.
    @(negedge clock);
    bus.ac_mul = 12'o36; bus.mq_mul = 12'o36;
    bus.req_valid = 1'b1; bus.req_op = MUY;
    bus.ac_in = 12'o11; bus.mq_in = 12'o22; bus.mb_in = 12'o33;
    @(negedge clock);
    bus.req_valid = 1'b0;
    guard = 0;
    while (bus.eae_start !== 1'b1 && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("rst_seq_started", 32'(bus.eae_start), 1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("rst_seq_ready", 32'(bus.req_ready), 1);
    checkOutput("rst_seq_ac_out_zero", 32'(bus.ac_out), 0);
    checkOutput("rst_seq_eae_ac_zero", 32'(bus.eae_ac), 0);
    bus.eae_fin_mul = 1'b1;
    dones = 0; readyDrops = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      bus.eae_fin_mul = 1'b0;
      if (bus.done !== 1'b0) dones++;
      if (bus.req_ready !== 1'b1) readyDrops++;
    end
    checkOutput("rst_seq_no_done", 32'(dones), 0);
    checkOutput("rst_seq_ready_held", 32'(readyDrops), 0);
    h = tbl[1]; h.name = "after_reset"; applyStimulus(h, 1'b0);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      r.op = (sel < 4) ? MUY : (sel < 8) ? DVI : 2'($urandom_range(0, 3));
      r.ac = 12'($urandom);
      r.mq = 12'($urandom);
      r.mb = 12'($urandom);
      if (r.op == DVI && r.mb != 0 && $urandom_range(0, 3) != 0)
        r.ac = 12'($urandom % r.mb);
      sel = $urandom_range(0, 9);
      r.finDly = (sel < 6) ? $urandom_range(1, 8) :
                 (sel < 8) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2) : NEVER;
      r.wrongDly = $urandom_range(0, 6);
      r.rAc   = 12'($urandom);
      r.rMq   = 12'($urandom);
      r.rLink = 1'($urandom);
      r.name  = $sformatf("rnd%0d", i);
      r = model(r);
      applyStimulus(r, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
